load_store_unit: RTL and testbench

- Memory-side producer for the writeback path: issues RV32I loads/stores to a word-organised data memory with variable wait states.
- Returns the aligned, sign/zero-extended load value (`mem_val` at the writeback mux) with a valid strobe.
- Sits between EX and the data memory; the writeback selector consumes resp_rdata when use_mem=1.

---
 rtl/load_store_unit_pkg.sv | 32 +++
 rtl/load_extend.sv | 27 ++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared widths, RV32I funct3 codes, FSM states and request legality check for the LSU.
package load_store_unit_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    // Flags illegal funct3 for the access direction or an address misaligned for its width.
    function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:         bad = 1'b0;
            F3_H:         bad = off[0];
            F3_W:         bad = (off != 2'b00);
            F3_BU, F3_HU: bad = we | off[0] & (f3 == F3_HU);
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns a memory word by byte offset and sign/zero-extends it per RV32I load width.
// Purely combinational.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] ext
);

    logic [DATA_WIDTH-1:0] sh;

    always_comb begin
        sh  = rdata >> {offset, 3'b000};
        ext = '0;
        case (funct3)
            F3_B:    ext = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            F3_BU:   ext = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            F3_H:    ext = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            F3_HU:   ext = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            F3_W:    ext = sh;
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: accept -> BUS (held until ack or timeout) -> one-cycle RESP.
// Latency accept+2 with zero-wait ack, accept+1 on error; req_ready only when idle, no queuing.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    lsu_state_t            state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [2:0]            lat_f3;
    logic [1:0]            lat_off;
    logic                  accept, bad, bus_done, timeout;
    logic [3:0]            strb_fmt;
    logic [DATA_WIDTH-1:0] wdata_fmt, ext;

    assign req_ready  = (state == LSU_IDLE);
    assign resp_valid = (state == LSU_RESP);
    assign bad        = req_illegal(req_we, req_funct3, req_addr[1:0]);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        bus_done  = 1'b0;
        timeout   = 1'b0;
        case (state)
            LSU_IDLE: if (req_valid) begin
                accept    = 1'b1;
                state_nxt = bad ? LSU_RESP : LSU_BUS;
            end
            LSU_BUS: begin
                // A same-cycle ack takes priority over the expiring timeout.
                if (mem_ack) begin
                    bus_done  = 1'b1;
                    state_nxt = LSU_RESP;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = LSU_RESP;
                end
            end
            LSU_RESP: state_nxt = LSU_IDLE;
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    always_comb begin
        strb_fmt  = 4'b0000;
        wdata_fmt = '0;
        if (req_we) begin
            case (req_funct3)
                F3_B: begin
                    strb_fmt  = 4'b0001 << req_addr[1:0];
                    wdata_fmt = {4{req_wdata[7:0]}};
                end
                F3_H: begin
                    strb_fmt  = 4'b0011 << req_addr[1:0];
                    wdata_fmt = {2{req_wdata[15:0]}};
                end
                default: begin
                    strb_fmt  = 4'b1111;
                    wdata_fmt = req_wdata;
                end
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata  (mem_rdata),
        .offset (lat_off),
        .funct3 (lat_f3),
        .ext    (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            lat_f3     <= 3'b000;
            lat_off    <= 2'b00;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= '0;
        end else if (accept) begin
            cnt     <= '0;
            lat_f3  <= req_funct3;
            lat_off <= req_addr[1:0];
            if (bad) begin
                resp_err   <= 1'b1;
                resp_rdata <= '0;
            end else begin
                mem_req   <= 1'b1;
                mem_we    <= req_we;
                mem_addr  <= {req_addr[DATA_WIDTH-1:2], 2'b00};
                mem_wstrb <= strb_fmt;
                mem_wdata <= wdata_fmt;
            end
        end else if (bus_done) begin
            mem_req    <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= mem_we ? '0 : ext;
        end else if (timeout) begin
            mem_req    <= 1'b0;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
        end else if (state == LSU_BUS) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scenario bench for load_store_unit; responses are checked against a scoreboard queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    int          o_req_cycles, o_resp_cycle, o_resp_cnt;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_we, o_stable;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Scoreboard: every response strobe is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            logic [32:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected: got rdata=%h err=%b with no request outstanding", resp_rdata, resp_err);
            end else begin
                e = exp_q.pop_front();
                if ({resp_err, resp_rdata} !== e) begin
                    failures++;
                    $display("FAIL resp_data: got err=%b rdata=%h expected err=%b rdata=%h",
                             resp_err, resp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        bit done;
        exp_q.push_back({exp_err, exp_rdata});
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_rdata = rdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        o_req_cycles = 0; o_resp_cycle = -1; o_resp_cnt = 0; o_stable = 1'b1;
        o_addr = 'x; o_wdata = 'x; o_wstrb = 'x; o_we = 'x;
        done = 0;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            if (mem_req) begin
                if (o_req_cycles == 0) begin
                    o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb; o_we = mem_we;
                end else if ({mem_addr, mem_wdata, mem_wstrb, mem_we} !== {o_addr, o_wdata, o_wstrb, o_we}) begin
                    o_stable = 1'b0;
                end
                o_req_cycles++;
                mem_ack = (o_req_cycles == waits + 1);
            end else begin
                mem_ack = 1'b0;
            end
            if (resp_valid) begin
                o_resp_cnt++;
                if (o_resp_cycle < 0) o_resp_cycle = c;
            end else if (o_resp_cycle >= 0) begin
                done = 1;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_req, mem_we} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got ready/valid/err/req/we=%b expected 10000",
                     {req_ready, resp_valid, resp_err, mem_req, mem_we});
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata, mem_wstrb} !== 100'd0) begin
            failures++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h wstrb=%b expected all zero",
                     resp_rdata, mem_addr, mem_wdata, mem_wstrb);
        end
    endtask

    task automatic test_lw_zero_wait;
        issue(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        checks++;
        if ({o_addr, o_wstrb, o_we} !== {32'h100, 4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL lw_bus: got addr=%h wstrb=%b we=%b expected 00000100 0000 0", o_addr, o_wstrb, o_we);
        end
        checks++;
        if (o_resp_cycle !== 2 || o_resp_cnt !== 1 || o_req_cycles !== 1) begin
            failures++;
            $display("FAIL lw_latency: got resp_cycle=%0d resp_cnt=%0d req_cycles=%0d expected 2 1 1",
                     o_resp_cycle, o_resp_cnt, o_req_cycles);
        end
    endtask

    task automatic test_load_extend;
        logic [2:0]  f3[4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad[4]  = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] ex[4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AA, 32'h000055CC};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3[i], ad[i], 32'h0, i, 32'h80AA55CC, ex[i], 1'b0);
            checks++;
            if (o_addr !== 32'h100 || o_resp_cycle !== i + 2) begin
                failures++;
                $display("FAIL load_ext_%0d: got addr=%h resp_cycle=%0d expected 00000100 %0d",
                         i, o_addr, o_resp_cycle, i + 2);
            end
        end
    endtask

    task automatic test_store_lanes;
        logic [2:0]  f3[3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] ad[3] = '{32'h201, 32'h202, 32'h204};
        logic [31:0] wd[3] = '{32'h123456AB, 32'h0000BEEF, 32'hCAFEF00D};
        logic [31:0] ea[3] = '{32'h200, 32'h200, 32'h204};
        logic [3:0]  es[3] = '{4'b0010, 4'b1100, 4'b1111};
        logic [31:0] ew[3] = '{32'hABABABAB, 32'hBEEFBEEF, 32'hCAFEF00D};
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, f3[i], ad[i], wd[i], (i == 0) ? 3 : 1, 32'hFFFFFFFF, 32'h0, 1'b0);
            checks++;
            if ({o_addr, o_wstrb, o_wdata, o_we} !== {ea[i], es[i], ew[i], 1'b1}) begin
                failures++;
                $display("FAIL store_lanes_%0d: got addr=%h wstrb=%b wdata=%h we=%b expected %h %b %h 1",
                         i, o_addr, o_wstrb, o_wdata, o_we, ea[i], es[i], ew[i]);
            end
            checks++;
            if (!o_stable || o_req_cycles !== ((i == 0) ? 4 : 2)) begin
                failures++;
                $display("FAIL store_hold_%0d: got stable=%b req_cycles=%0d expected 1 %0d",
                         i, o_stable, o_req_cycles, (i == 0) ? 4 : 2);
            end
        end
    endtask

    task automatic test_errors;
        logic        we[3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  f3[3] = '{3'b010, 3'b011, 3'b011};
        logic [31:0] ad[3] = '{32'h102, 32'h100, 32'h100};
        for (int i = 0; i < 3; i++) begin
            issue(we[i], f3[i], ad[i], 32'h55, 0, 32'h12345678, 32'h0, 1'b1);
            checks++;
            if (o_req_cycles !== 0 || o_resp_cycle !== 1 || o_resp_cnt !== 1) begin
                failures++;
                $display("FAIL error_path_%0d: got req_cycles=%0d resp_cycle=%0d resp_cnt=%0d expected 0 1 1",
                         i, o_req_cycles, o_resp_cycle, o_resp_cnt);
            end
        end
    endtask

    task automatic test_timeout;
        issue(1'b0, 3'b010, 32'h180, 32'h0, 1000, 32'h11111111, 32'h0, 1'b1);
        checks++;
        if (o_req_cycles !== 16 || o_resp_cycle !== 17) begin
            failures++;
            $display("FAIL timeout: got req_cycles=%0d resp_cycle=%0d expected 16 17", o_req_cycles, o_resp_cycle);
        end
    endtask

    task automatic test_reset_mid_bus;
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: got mem_req=%b expected 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got mem_req=%b resp_valid=%b expected 0 0", mem_req, resp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checks++;
        if (seen !== 0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_after: got resp_valid_cycles=%0d req_ready=%b expected 0 1", seen, req_ready);
        end
    endtask

    task automatic test_back_to_back;
        issue(1'b0, 3'b000, 32'h401, 32'h0, 0, 32'h00007F00, 32'h0000007F, 1'b0);
        issue(1'b0, 3'b001, 32'h402, 32'h0, 0, 32'hF00D0000, 32'hFFFFF00D, 1'b0);
        checks++;
        if (o_resp_cycle !== 2 || o_addr !== 32'h400) begin
            failures++;
            $display("FAIL back_to_back: got resp_cycle=%0d addr=%h expected 2 00000400", o_resp_cycle, o_addr);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_lw_zero_wait;
        test_load_extend;
        test_store_lanes;
        test_errors;
        test_timeout;
        test_reset_mid_bus;
        test_back_to_back;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL resp_missing: got %0d outstanding expectations expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
